// File: rtl/v_logic_issue_seq_if.sv
// Bus bundle for the vector logic operand sequencer.
// Groups the command handshake, register-file read port, ALU request port,
// ALU response strobe and the busy/done status.
//   master : the sequencer (drives cmd_ready, rd_*, alu_*, busy, done)
//   slave  : the surrounding dispatch / register file / ALU environment
interface v_logic_issue_seq_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned OPSEL_WIDTH = 2
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [OPSEL_WIDTH-1:0] cmd_op;
  logic [ADDR_WIDTH-1:0]  cmd_vs1;
  logic [ADDR_WIDTH-1:0]  cmd_vs2;
  logic [ADDR_WIDTH-1:0]  cmd_vd;
  logic [LEN_WIDTH-1:0]   cmd_len;

  logic                   rd_en;
  logic                   rd_gnt;
  logic [ADDR_WIDTH-1:0]  rd_addr0;
  logic [ADDR_WIDTH-1:0]  rd_addr1;
  logic [DATA_WIDTH-1:0]  rd_data0;
  logic [DATA_WIDTH-1:0]  rd_data1;

  logic                   alu_valid;
  logic [DATA_WIDTH-1:0]  alu_vec0;
  logic [DATA_WIDTH-1:0]  alu_vec1;
  logic [OPSEL_WIDTH-1:0] alu_opSel;
  logic [ADDR_WIDTH-1:0]  alu_addr;
  logic                   alu_resp_valid;

  logic                   busy;
  logic                   done;

  modport master (
    input  cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_len,
    input  rd_gnt, rd_data0, rd_data1, alu_resp_valid,
    output cmd_ready, rd_en, rd_addr0, rd_addr1,
    output alu_valid, alu_vec0, alu_vec1, alu_opSel, alu_addr,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_len,
    output rd_gnt, rd_data0, rd_data1, alu_resp_valid,
    input  cmd_ready, rd_en, rd_addr0, rd_addr1,
    input  alu_valid, alu_vec0, alu_vec1, alu_opSel, alu_addr,
    input  busy, done
  );
endinterface

// File: rtl/v_logic_issue_seq.sv
// Operand sequencer for the pipelined vector AND/OR/XOR unit.
// Accepts one vector command, reads operand pairs from the register file one
// beat per granted cycle, forwards each pair to the ALU the following cycle
// with its destination address, and counts ALU results back, pulsing done
// once all beats have returned.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : v_logic_issue_seq_if.master (command, RF read, ALU request/response,
//         busy/done status)
module v_logic_issue_seq #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned OPSEL_WIDTH = 2
) (
  input logic              clk,
  input logic              rst,
  v_logic_issue_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [OPSEL_WIDTH-1:0] op_q, op_d;
  logic [ADDR_WIDTH-1:0]  vs1_q, vs1_d;
  logic [ADDR_WIDTH-1:0]  vs2_q, vs2_d;
  logic [ADDR_WIDTH-1:0]  vd_q, vd_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   i_q, i_d;
  logic [LEN_WIDTH-1:0]   r_q, r_d;
  logic                   iss_q, iss_d;
  logic [ADDR_WIDTH-1:0]  iss_addr_q, iss_addr_d;
  logic                   done_q, done_d;
  // Holds cmd_ready low until the first clock edge after reset release.
  logic                   init_q, init_d;

  logic                   r_inc;
  logic [LEN_WIDTH-1:0]   r_next;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vd_d       = vd_q;
    len_d      = len_q;
    i_d        = i_q;
    r_d        = r_q;
    iss_d      = 1'b0;
    iss_addr_d = iss_addr_q;
    done_d     = 1'b0;
    init_d     = 1'b1;

    // Responses only count while a command is live, and never past len.
    r_inc  = bus.alu_resp_valid && (state_q != S_IDLE) && (r_q != len_q);
    r_next = r_q + (r_inc ? LEN_ONE : '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && init_q) begin
          op_d  = bus.cmd_op;
          vs1_d = bus.cmd_vs1;
          vs2_d = bus.cmd_vs2;
          vd_d  = bus.cmd_vd;
          len_d = bus.cmd_len;
          i_d   = '0;
          r_d   = '0;
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        r_d = r_next;
        if (bus.rd_gnt) begin
          iss_d      = 1'b1;
          iss_addr_d = vd_q + ADDR_WIDTH'(i_q);
          i_d        = i_q + LEN_ONE;
          if (i_q == len_q - LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        r_d = r_next;
        if (r_next == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      len_q      <= '0;
      i_q        <= '0;
      r_q        <= '0;
      iss_q      <= 1'b0;
      iss_addr_q <= '0;
      done_q     <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      vd_q       <= vd_d;
      len_q      <= len_d;
      i_q        <= i_d;
      r_q        <= r_d;
      iss_q      <= iss_d;
      iss_addr_q <= iss_addr_d;
      done_q     <= done_d;
      init_q     <= init_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && init_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.rd_en     = (state_q == S_READ);
  assign bus.rd_addr0  = bus.rd_en ? (vs1_q + ADDR_WIDTH'(i_q)) : '0;
  assign bus.rd_addr1  = bus.rd_en ? (vs2_q + ADDR_WIDTH'(i_q)) : '0;

  // RF data arrives the cycle after the grant, aligned with iss_q.
  assign bus.alu_valid = iss_q;
  assign bus.alu_vec0  = iss_q ? bus.rd_data0 : '0;
  assign bus.alu_vec1  = iss_q ? bus.rd_data1 : '0;
  assign bus.alu_opSel = iss_q ? op_q : '0;
  assign bus.alu_addr  = iss_q ? iss_addr_q : '0;

endmodule

// File: tb/tb_v_logic_issue_seq.sv
module tb_v_logic_issue_seq;

  logic clk;
  logic rst;
  logic stray;
  logic [5:0] alu_pipe = '0;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  v_logic_issue_seq_if #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(16), .OPSEL_WIDTH(2)
  ) bus ();

  v_logic_issue_seq #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(16), .OPSEL_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] f0(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [63:0] f1(input logic [31:0] a);
    return {~a ^ 32'h5A5A_5A5A, a};
  endfunction

  // Register file model: data one cycle after a granted read.
  always @(posedge clk) begin
    if (bus.rd_en && bus.rd_gnt) begin
      bus.rd_data0 <= f0(bus.rd_addr0);
      bus.rd_data1 <= f1(bus.rd_addr1);
    end
  end

  // ALU model: 6-cycle latency, not reset, so in-flight results survive reset.
  always @(posedge clk) alu_pipe <= {alu_pipe[4:0], bus.alu_valid};
  assign bus.alu_resp_valid = alu_pipe[5] | stray;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] vs1;
    logic [31:0] vs2;
    logic [31:0] vd;
    logic [15:0] len;
    logic [15:0] gnt_pat;   // bit k = rd_gnt in cycle T+1+k
    int unsigned exp_done;  // done cycle offset from accept cycle T
  } vec_t;

  vec_t tbl[5];

  task automatic run_cmd(input vec_t v);
    int unsigned grants;
    int unsigned issues;
    logic [31:0] e0, e1, ed;
    grants = 0;
    issues = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_vs1   = v.vs1;
    bus.cmd_vs2   = v.vs2;
    bus.cmd_vd    = v.vd;
    bus.cmd_len   = v.len;
    bus.rd_gnt    = 1'b0;
    @(negedge clk);
    check("cmd_ready_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int unsigned off = 1; off <= v.exp_done + 2; off++) begin
      if (off > 1) begin
        @(posedge clk); #1;
      end
      bus.rd_gnt = v.gnt_pat[(off - 1) % 16];
      @(negedge clk);
      check("done", bus.done, (off == v.exp_done));
      check("busy", bus.busy, (off < v.exp_done));
      check("cmd_ready", bus.cmd_ready, (off >= v.exp_done));
      if (bus.rd_en) begin
        e0 = v.vs1 + grants;
        e1 = v.vs2 + grants;
        check("rd_addr0", bus.rd_addr0, e0);
        check("rd_addr1", bus.rd_addr1, e1);
        if (bus.rd_gnt) grants++;
      end
      if (bus.alu_valid) begin
        e0 = v.vs1 + issues;
        e1 = v.vs2 + issues;
        ed = v.vd + issues;
        check("alu_addr", bus.alu_addr, ed);
        check("alu_vec0", bus.alu_vec0, f0(e0));
        check("alu_vec1", bus.alu_vec1, f1(e1));
        check("alu_opSel", bus.alu_opSel, v.op);
        issues++;
      end else begin
        check("alu_idle_zero",
              |{bus.alu_vec0, bus.alu_vec1, bus.alu_addr, bus.alu_opSel}, 0);
      end
    end
    check("grant_count", grants, v.len);
    check("issue_count", issues, v.len);
    bus.rd_gnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t rv;
    tbl[0] = '{op: 2'b11, vs1: 32'h10, vs2: 32'h20, vd: 32'h30,
               len: 16'd4, gnt_pat: 16'hFFFF, exp_done: 12};
    tbl[1] = '{op: 2'b01, vs1: 32'h100, vs2: 32'h200, vd: 32'h300,
               len: 16'd3, gnt_pat: 16'hAAAA, exp_done: 14};
    tbl[2] = '{op: 2'b10, vs1: 32'h1, vs2: 32'h2, vd: 32'h3,
               len: 16'd0, gnt_pat: 16'hFFFF, exp_done: 1};
    tbl[3] = '{op: 2'b11, vs1: 32'hFFFF_FFFE, vs2: 32'h5, vd: 32'hFFFF_FFFF,
               len: 16'd4, gnt_pat: 16'hFFFF, exp_done: 12};
    tbl[4] = '{op: 2'b00, vs1: 32'h40, vs2: 32'h50, vd: 32'h60,
               len: 16'd2, gnt_pat: 16'hFFFD, exp_done: 11};

    rst           = 1'b0;
    stray         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_vs1   = 32'h0;
    bus.cmd_vs2   = 32'h0;
    bus.cmd_vd    = 32'h0;
    bus.cmd_len   = 16'd1;
    bus.rd_gnt    = 1'b1;

    // Reset held with a command offered: everything quiet.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_alu_valid", bus.alu_valid, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_alu_bus", |{bus.alu_vec0, bus.alu_vec1, bus.alu_addr, bus.alu_opSel}, 0);
    end
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rd_gnt    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_busy", bus.busy, 0);

    for (int k = 0; k < 5; k++) run_cmd(tbl[k]);

    // Mid-command reset after two issues of a five-beat command.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_vs1   = 32'h80;
    bus.cmd_vs2   = 32'h90;
    bus.cmd_vd    = 32'hA0;
    bus.cmd_len   = 16'd5;
    bus.rd_gnt    = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_issue1", bus.alu_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_issue2", bus.alu_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_rd_en", bus.rd_en, 0);
    check("midrst_alu_valid", bus.alu_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("midrst_done", bus.done, 0);
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.rd_gnt    = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      stray = (k == 2 || k == 3 || k == 9);
      @(negedge clk);
      check("after_rst_done", bus.done, 0);
      check("after_rst_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
    stray = 1'b0;
    repeat (2) @(posedge clk);

    rv = '{op: 2'b10, vs1: 32'h7, vs2: 32'h8, vd: 32'h9,
           len: 16'd1, gnt_pat: 16'hFFFF, exp_done: 9};
    run_cmd(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/v_logic_issue_seq.md
# v_logic_issue_seq

Operand sequencer that drives the pipelined vector AND/OR/XOR unit. It accepts one logical vector command (op, two source base addresses, destination base address, beat count) and reads operand pairs from the vector register file one beat per granted cycle. It issues each pair to the ALU with the matching destination address, then counts returning ALU results and pulses `done` once every beat has come back. It sits between the vector decode/dispatch stage and the ALU request port.

## Interface
- `DATA_WIDTH`, 64, operand/beat width
- `ADDR_WIDTH`, 32, register-file beat address width
- `LEN_WIDTH`, 16, beat-count width
- `OPSEL_WIDTH`, 2, ALU op select width (01=and, 10=or, 11=xor, 00=zero result)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: sequencer can accept a command
- `cmd_op` in OPSEL_WIDTH: ALU op for all beats
- `cmd_vs1`, `cmd_vs2`, `cmd_vd` in ADDR_WIDTH: source 0/1 and destination base beat addresses
- `cmd_len` in LEN_WIDTH: number of beats
- `rd_en` out 1: register-file read request
- `rd_gnt` in 1: read accepted this cycle
- `rd_addr0`, `rd_addr1` out ADDR_WIDTH: read addresses
- `rd_data0`, `rd_data1` in DATA_WIDTH: read data, valid exactly 1 cycle after `rd_en & rd_gnt`
- `alu_valid` out 1, `alu_vec0`/`alu_vec1` out DATA_WIDTH, `alu_opSel` out OPSEL_WIDTH, `alu_addr` out ADDR_WIDTH: ALU request
- `alu_resp_valid` in 1: ALU result valid (ALU output valid)
- `busy` out 1: command in progress
- `done` out 1: one-cycle pulse, command complete

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - `cmd_ready` = 1, `busy` = 0.
  - On `cmd_valid & cmd_ready`, latch op/vs1/vs2/vd/len and clear the beat index `i` and the response count `r`.
  - If len = 0: stay in IDLE and pulse `done` next cycle. Otherwise go to READ.
- READ:
  - `rd_en` = 1, `rd_addr0` = vs1+i, `rd_addr1` = vs2+i.
  - On `rd_gnt`: i increments. On the last beat (i = len−1), go to DRAIN.
  - Without `rd_gnt`: hold the same addresses and retry.
- Issue stage:
  - The cycle after a granted read: `alu_valid` = 1, `alu_vec0`/`alu_vec1` = `rd_data0`/`rd_data1` (combinational pass of RF data), `alu_opSel` = latched op.
  - `alu_addr` = vd+i, with i taken at grant and registered.
  - At most one issue per cycle, in beat order.
  - When not issuing, all `alu_*` data outputs are 0.
- Response count:
  - `r` increments on `alu_resp_valid` in READ or DRAIN. Responses in IDLE are ignored.
  - DRAIN: when `r` = len (counting the current-cycle response), go to IDLE and pulse `done` on the following cycle.
- Arithmetic:
  - All address sums are modulo 2^ADDR_WIDTH; wrap is silent.
  - `i` and `r` are LEN_WIDTH wide and never exceed len.
- `busy` = 1 in READ and DRAIN.
- Reset asserted (`rst`=0), asynchronously:
  - state → IDLE, counters and latches → 0.
  - `rd_en`, `alu_valid`, `done`, `busy`, `cmd_ready` all = 0 while reset is held; all `alu_*` buses = 0.
  - Mid-command reset abandons the command with no `done`. ALU results still in flight are ignored on return.
- A new command is not accepted until the `done` of the previous one is scheduled (FSM back in IDLE).

## Timing
- Command accepted at cycle T → first `rd_en` at T+1 → first `alu_valid` at T+2 (with `rd_gnt`=1).
- With continuous grant and len=N:
  - last read at T+N, last issue at T+N+1.
  - The ALU has 6-cycle latency, so the last response arrives at T+N+7 and `done` pulses at T+N+8.
  - `cmd_ready` reasserts at T+N+8.
- Each deasserted-grant cycle delays every later event by one cycle.
- `done` is exactly one cycle wide. The same-cycle accept of a new command is allowed in the `done` cycle (FSM is in IDLE).

## Test plan
- Reset held low with `cmd_valid`=1 → `cmd_ready`, `rd_en`, `alu_valid`, `done`, `busy` all 0; after release, `cmd_ready`=1 in the next cycle.
- XOR command, vs1=0x10, vs2=0x20, vd=0x30, len=4, grant always, model ALU 6-cycle delay:
  - rd_addr0 sequence is 0x10..0x13; `alu_addr` sequence is 0x30..0x33 at T+2..T+5.
  - `done` pulses at T+12.
- len=3 with `rd_gnt` low on alternate cycles → read addresses are held during stalls; issues are in order with no duplicates; exactly 3 `alu_valid` pulses; `done` follows the third response by one cycle.
- len=0 accepted at T → no `rd_en`, no `alu_valid`, `done` at T+1, `cmd_ready` stays 1.
- vs1=0xFFFFFFFE, len=4 → rd_addr0 sequence is 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset pulsed after 2 of 5 issues → FSM goes to IDLE immediately with no `done`. Stray `alu_resp_valid` pulses afterwards do not count. A following len=1 command completes with `done` at T+9.
